// File: rtl/vga_rect_gen.sv
// VGA timing generator with a prioritised multi-rectangle overlay.
// Rectangle configuration is double-buffered and swapped only at frame boundaries.
module vga_rect_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int R_W      = 3,
   parameter int G_W      = 3,
   parameter int B_W      = 2,
   parameter int NUM_RECT = 4,
   parameter int XY_W     = 11,
   parameter logic [R_W+G_W+B_W-1:0] BG_COLOR = '0,
   localparam int CW = R_W + G_W + B_W,
   localparam int IW = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1
) (
   input  logic            sys_clk,
   input  logic            rst_n,
   input  logic            cfg_we,
   input  logic [IW-1:0]   cfg_idx,
   input  logic [XY_W-1:0] cfg_x0,
   input  logic [XY_W-1:0] cfg_y0,
   input  logic [XY_W-1:0] cfg_x1,
   input  logic [XY_W-1:0] cfg_y1,
   input  logic [CW-1:0]   cfg_color,
   input  logic            cfg_en,
   input  logic            cfg_commit,
   output logic            VGA_CLK,
   output logic [R_W-1:0]  VGA_R,
   output logic [G_W-1:0]  VGA_G,
   output logic [B_W-1:0]  VGA_B,
   output logic            VGA_HS,
   output logic            VGA_VS,
   output logic            VGA_BLANK_N,
   output logic            VGA_SYNC_N,
   output logic            frame_start,
   output logic [XY_W-1:0] pix_x,
   output logic [XY_W-1:0] pix_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);

   typedef logic [XY_W-1:0] coord_t;

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
   localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
   localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);
   localparam logic          HS_ON  = (HS_POL != 0);
   localparam logic          VS_ON  = (VS_POL != 0);

   typedef struct packed {
      coord_t        x0;
      coord_t        y0;
      coord_t        x1;
      coord_t        y1;
      logic [CW-1:0] color;
   } geo_t;

   logic [DW-1:0]       dcnt, dcnt_nxt;
   logic                pe;
   coord_t              h_cnt, v_cnt;
   logic                h_last, v_last, boundary;
   logic                pending, do_copy, idx_ok;
   logic [NUM_RECT-1:0] sh_en, ac_en;
   geo_t                sh_geo [NUM_RECT];
   geo_t                ac_geo [NUM_RECT];
   logic [CW-1:0]       pix_color;
   logic                in_active, hs_act, vs_act;

   assign pe         = (dcnt == D_LAST);
   assign dcnt_nxt   = pe ? '0 : dcnt + 1'b1;
   assign h_last     = (h_cnt == H_LAST);
   assign v_last     = (v_cnt == V_LAST);
   assign boundary   = pe && h_last && v_last;
   assign do_copy    = boundary && pending;
   assign idx_ok     = (int'(cfg_idx) < NUM_RECT);
   assign in_active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_act     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs_act     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign VGA_SYNC_N = 1'b0;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt    <= '0;
         VGA_CLK <= 1'b0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         dcnt    <= dcnt_nxt;
         VGA_CLK <= (dcnt_nxt >= D_HALF);
         if (pe) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end
      end
   end

   // A commit landing on the boundary cycle re-arms pending for the next frame.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_en   <= '0;
         ac_en   <= '0;
         pending <= 1'b0;
      end else begin
         if (do_copy) ac_en <= sh_en;
         if (cfg_we && idx_ok) sh_en[cfg_idx] <= cfg_en;
         if (cfg_commit) pending <= 1'b1;
         else if (boundary) pending <= 1'b0;
      end
   end

   // NOTE: geometry storage has no reset; a slot is only visible once its reset-cleared enable is set.
   always_ff @(posedge sys_clk) begin
      if (do_copy) ac_geo <= sh_geo;
      if (cfg_we && idx_ok) sh_geo[cfg_idx] <= {cfg_x0, cfg_y0, cfg_x1, cfg_y1, cfg_color};
   end

   // NOTE: pix_color gets its default before the loop so no latch is inferred.
   always_comb begin
      pix_color = BG_COLOR;
      for (int i = NUM_RECT - 1; i >= 0; i--) begin
         if (ac_en[i] &&
             (h_cnt >= ac_geo[i].x0) && (h_cnt < ac_geo[i].x1) &&
             (v_cnt >= ac_geo[i].y0) && (v_cnt < ac_geo[i].y1))
            pix_color = ac_geo[i].color;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= ~HS_ON;
         VGA_VS      <= ~VS_ON;
         VGA_BLANK_N <= 1'b0;
         frame_start <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
      end else begin
         frame_start <= pe && (h_cnt == '0) && (v_cnt == '0);
         if (pe) begin
            VGA_R       <= in_active ? pix_color[CW-1 -: R_W]      : '0;
            VGA_G       <= in_active ? pix_color[G_W+B_W-1 -: G_W] : '0;
            VGA_B       <= in_active ? pix_color[B_W-1:0]          : '0;
            VGA_HS      <= hs_act ? HS_ON : ~HS_ON;
            VGA_VS      <= vs_act ? VS_ON : ~VS_ON;
            VGA_BLANK_N <= in_active;
            pix_x       <= h_cnt;
            pix_y       <= v_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vga_rect_gen.sv
// Self-checking bench for vga_rect_gen on a small screen geometry, with a
// per-sys_clk reference model computed from pixel index arithmetic.
module tb_vga_rect_gen;

   localparam int CLK_DIV = 4;
   localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2;
   localparam int VA = 10, VFP = 1, VSY = 2, VBP = 1;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;
   localparam int FC = FT * CLK_DIV;
   localparam int NR = 3;
   localparam int HS_POL = 1, VS_POL = 0;
   localparam logic [7:0] BG = 8'h25;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic        cfg_we, cfg_en, cfg_commit;
   logic [1:0]  cfg_idx;
   logic [10:0] cfg_x0, cfg_y0, cfg_x1, cfg_y1;
   logic [7:0]  cfg_color;
   logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
   logic [2:0]  VGA_R, VGA_G;
   logic [1:0]  VGA_B;
   logic [10:0] pix_x, pix_y;

   vga_rect_gen #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .NUM_RECT(NR), .BG_COLOR(BG)
   ) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
      .cfg_color(cfg_color), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
      .VGA_CLK(VGA_CLK), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N(VGA_SYNC_N), .frame_start(frame_start),
      .pix_x(pix_x), .pix_y(pix_y)
   );

   initial forever #5 sys_clk = ~sys_clk;

   typedef struct {
      int x0, y0, x1, y1, color;
      bit en;
   } rect_m_t;

   rect_m_t m_shadow [NR];
   rect_m_t m_active [NR];
   bit      m_pending;
   int      t, prev_fs;
   int      e_rgb, e_hs, e_vs, e_blank, e_px, e_py, e_fs, e_clk;
   int      n_checks = 0;
   int      n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      t       = 0;
      prev_fs = -1;
      m_pending = 0;
      for (int i = 0; i < NR; i++) begin
         m_shadow[i].en = 0;
         m_active[i].en = 0;
      end
      e_rgb = 0; e_hs = 1 - HS_POL; e_vs = 1 - VS_POL; e_blank = 0;
      e_px = 0; e_py = 0; e_fs = 0; e_clk = 0;
   endtask

   // Expected outputs after sys_clk edge number t since reset release.
   task automatic model_edge();
      int p, h, v, col;
      bit hit;
      t++;
      e_fs = 0;
      if (t % CLK_DIV == 0) begin
         p = t / CLK_DIV - 1;
         h = p % HT;
         v = (p / HT) % VT;
         e_px    = h;
         e_py    = v;
         e_blank = (h < HA && v < VA) ? 1 : 0;
         e_hs    = (h >= HA + HFP && h < HA + HFP + HSY) ? HS_POL : 1 - HS_POL;
         e_vs    = (v >= VA + VFP && v < VA + VFP + VSY) ? VS_POL : 1 - VS_POL;
         col = BG;
         hit = 0;
         for (int i = 0; i < NR; i++) begin
            if (!hit && m_active[i].en && h >= m_active[i].x0 && h < m_active[i].x1 &&
                v >= m_active[i].y0 && v < m_active[i].y1) begin
               col = m_active[i].color;
               hit = 1;
            end
         end
         e_rgb = e_blank ? col : 0;
         e_fs  = (p % FT == 0) ? 1 : 0;
      end
      e_clk = ((t % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0;
      if (t % FC == 0 && m_pending) begin
         m_active  = m_shadow;
         m_pending = 0;
      end
      if (cfg_commit) m_pending = 1;
      if (cfg_we && cfg_idx < NR)
         m_shadow[cfg_idx] = '{x0: int'(cfg_x0), y0: int'(cfg_y0), x1: int'(cfg_x1),
                               y1: int'(cfg_y1), color: int'(cfg_color), en: cfg_en};
   endtask

   task automatic tick();
      @(posedge sys_clk);
      model_edge();
      #1;
      check("rgb",     {VGA_R, VGA_G, VGA_B}, e_rgb);
      check("hs",      VGA_HS, e_hs);
      check("vs",      VGA_VS, e_vs);
      check("blank_n", VGA_BLANK_N, e_blank);
      check("sync_n",  VGA_SYNC_N, 1'b0);
      check("pix_x",   pix_x, e_px);
      check("pix_y",   pix_y, e_py);
      check("fs",      frame_start, e_fs);
      check("vga_clk", VGA_CLK, e_clk);
      if (frame_start === 1'b1) begin
         if (prev_fs >= 0) check("fs_period", t - prev_fs, FC);
         prev_fs = t;
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rgb"},   {VGA_R, VGA_G, VGA_B}, 8'h00);
      check({tag, "_hs"},    VGA_HS, 1 - HS_POL);
      check({tag, "_vs"},    VGA_VS, 1 - VS_POL);
      check({tag, "_blank"}, VGA_BLANK_N, 1'b0);
      check({tag, "_clk"},   VGA_CLK, 1'b0);
      check({tag, "_fs"},    frame_start, 1'b0);
      check({tag, "_pix"},   {pix_y, pix_x}, 22'd0);
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      #2;
      check_reset("rst_async");
      repeat (hold) @(posedge sys_clk);
      #1;
      check_reset("rst_held");
      @(negedge sys_clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_rect(input int idx, input int x0, input int y0, input int x1, input int y1,
                           input int color, input bit en, input bit commit);
      cfg_idx   = 2'(idx);
      cfg_x0    = 11'(x0);
      cfg_y0    = 11'(y0);
      cfg_x1    = 11'(x1);
      cfg_y1    = 11'(y1);
      cfg_color = 8'(color);
      cfg_en    = en;
      cfg_we    = 1'b1;
      cfg_commit = commit;
      tick();
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
   endtask

   task automatic commit_pulse();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic wait_pix(input int x, input int y);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(pix_x == 11'(x) && pix_y == 11'(y)) && n < 2 * FC);
      check("wait_pix", {pix_y, pix_x}, {11'(y), 11'(x)});
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         tick();
         n++;
      end while (frame_start !== 1'b1 && n < 2 * FC);
      check("wait_frame", frame_start, 1'b1);
   endtask

   task automatic pix_check(input string tag, input int x, input int y, input logic [7:0] exp);
      wait_pix(x, y);
      check(tag, {VGA_R, VGA_G, VGA_B}, exp);
   endtask

   task automatic to_boundary();
      while ((t + 1) % FC != 0) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_commit = 1'b0; cfg_en = 1'b0; cfg_idx = '0;
      cfg_x0 = '0; cfg_y0 = '0; cfg_x1 = '0; cfg_y1 = '0; cfg_color = '0;
      for (int i = 0; i < NR; i++) begin
         m_shadow[i] = '{default: 0};
         m_active[i] = '{default: 0};
      end
      model_reset();
      repeat (2) @(posedge sys_clk);
      #1;
      check_reset("por");
      @(negedge sys_clk);
      rst_n = 1'b1;

      // Free-running timing with nothing enabled.
      run(2 * FC + 50);

      // Mid-frame commit: current frame stays background, next frame shows rect0.
      wait_pix(0, 1);
      set_rect(0, 4, 2, 9, 6, 8'hE0, 1'b1, 1'b1);
      pix_check("cur_frame_bg", 5, 3, BG);
      wait_frame();
      pix_check("r0_corner",  4, 2, 8'hE0);
      pix_check("r0_x1_edge", 9, 2, BG);
      pix_check("r0_inner",   8, 5, 8'hE0);
      pix_check("r0_y1_edge", 8, 6, BG);

      // Priority: lowest index wins; blanking forces zero past the active width.
      set_rect(1, 0, 0, 16, 10, 8'h03, 1'b1, 1'b0);
      set_rect(0, 3, 3, 6, 6, 8'h1C, 1'b1, 1'b0);
      set_rect(2, 12, 1, 20, 4, 8'hFF, 1'b1, 1'b1);
      wait_frame();
      pix_check("prio_green", 3, 3, 8'h1C);
      pix_check("prio_blue",  6, 3, 8'h03);
      pix_check("hidden_r2",  14, 2, 8'h03);
      wait_frame();
      set_rect(1, 0, 0, 16, 10, 8'h03, 1'b0, 1'b1);
      wait_frame();
      pix_check("r2_visible", 14, 2, 8'hFF);
      pix_check("r2_blanked", 17, 2, 8'h00);
      pix_check("r2_last",    15, 3, 8'hFF);

      // Commit sampled on the boundary cycle waits for the following boundary.
      set_rect(0, 3, 3, 6, 6, 8'hE0, 1'b1, 1'b0);
      to_boundary();
      commit_pulse();
      wait_frame();
      pix_check("late_commit_old", 3, 3, 8'h1C);
      wait_frame();
      pix_check("late_commit_new", 3, 3, 8'hE0);

      // Out-of-range index is ignored.
      set_rect(3, 0, 0, 16, 10, 8'hFF, 1'b1, 1'b1);
      wait_frame();
      pix_check("bad_idx_a", 1, 0, BG);
      pix_check("bad_idx_b", 8, 8, BG);

      // Write on the copy cycle: copy takes the pre-write shadow value.
      set_rect(0, 3, 3, 6, 6, 8'h1C, 1'b1, 1'b1);
      to_boundary();
      set_rect(0, 3, 3, 6, 6, 8'h03, 1'b1, 1'b0);
      wait_frame();
      pix_check("copy_old", 3, 3, 8'h1C);
      commit_pulse();
      wait_frame();
      pix_check("copy_new", 3, 3, 8'h03);

      // Randomised configuration traffic against the model.
      for (int r = 0; r < 10; r++) begin
         int nw;
         nw = $urandom_range(1, 4);
         for (int k = 0; k < nw; k++) begin
            set_rect($urandom_range(0, 3), $urandom_range(0, HT), $urandom_range(0, VT),
                     $urandom_range(0, HT), $urandom_range(0, VT), $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            run($urandom_range(0, 40));
         end
         if ($urandom_range(0, 1) == 1) commit_pulse();
         run($urandom_range(200, 1500));
      end

      // Mid-frame reset: everything restarts from (0,0) with no rectangles.
      wait_pix(0, 5);
      do_reset(3);
      wait_frame();
      pix_check("post_rst_a", 3, 3, BG);
      pix_check("post_rst_b", 14, 2, BG);
      run(FC);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
